// File: rtl/distributive_checker_pkg.sv
// Shared types and constants for the distributive-law response checker.
package dl_check_pkg;

  // Checker run phases.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of distinct {x,y,z} stimulus vectors.
  localparam int NUM_VEC = 8;

  // Coverage mask once every vector has been observed.
  localparam logic [NUM_VEC-1:0] ALL_COVERED = 8'hFF;

  // Failure source: bit1 = s0 wrong, bit0 = s1 wrong.
  typedef logic [1:0] err_src_t;

  // Pack the stimulus bits into a vector index, x being the MSB.
  function automatic logic [2:0] vec_idx(input logic x, input logic y, input logic z);
    return {x, y, z};
  endfunction

endpackage

// File: rtl/distributive_checker_if.sv
// Sample bus between the stimulus driver and the checker, plus the result readout.
interface distributive_checker_if
  import dl_check_pkg::*;
#(
  parameter int CNT_W = 8
);

  // Run control and one strobed observation.
  logic start;
  logic sample_en;
  logic x;
  logic y;
  logic z;
  logic s0;
  logic s1;

  // Run status and captured results.
  logic               busy;
  logic               done;
  logic               pass;
  logic [NUM_VEC-1:0] coverage;
  logic [CNT_W-1:0]   err_cnt;
  logic [CNT_W-1:0]   sample_cnt;
  logic               first_err_valid;
  logic [2:0]         first_err_vec;
  err_src_t           first_err_src;

  // Stimulus driver side.
  modport master (
    output start, sample_en, x, y, z, s0, s1,
    input  busy, done, pass, coverage, err_cnt, sample_cnt,
           first_err_valid, first_err_vec, first_err_src
  );

  // Checker side.
  modport slave (
    input  start, sample_en, x, y, z, s0, s1,
    output busy, done, pass, coverage, err_cnt, sample_cnt,
           first_err_valid, first_err_vec, first_err_src
  );

endinterface

// File: rtl/distributive_checker_golden.sv
// Golden model of the distributive-law experiment: exp = x + (y . z).
// Purely combinational so other lab checkers can reuse it.
module distributive_golden (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic exp
);

  assign exp = x | (y & z);

endmodule

// File: rtl/distributive_checker.sv
// Response checker for the distributive-law gate experiment. Compares the
// sum-of-product (s0) and product-of-sum (s1) networks against the golden
// value on every strobed sample, tracks vector coverage, counts errors and
// latches the first failing vector.
module distributive_checker
  import dl_check_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int MAX_SAMPLES = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  distributive_checker_if.slave bus
);

  // Reject budgets that can never reach full coverage or overflow the counter.
  if (MAX_SAMPLES < NUM_VEC || MAX_SAMPLES >= (1 << CNT_W)) begin : g_bad_budget
    $error("distributive_checker: MAX_SAMPLES must be >= 8 and < 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SAMPLES);

  state_t             state_q, state_d;
  logic [NUM_VEC-1:0] cov_q, cov_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fev_q, fev_d;
  logic [2:0]         fvec_q, fvec_d;
  err_src_t           fsrc_q, fsrc_d;
  logic               busy_q, done_q, pass_q;
  logic               pass_d;

  logic               exp;
  logic [2:0]         idx;
  logic               take;
  logic               bad0;
  logic               bad1;

  distributive_golden u_golden (
    .x   (bus.x),
    .y   (bus.y),
    .z   (bus.z),
    .exp (exp)
  );

  assign idx  = vec_idx(bus.x, bus.y, bus.z);
  // A sample landing together with start belongs to no run and is dropped.
  assign take = (state_q == RUN) && bus.sample_en && !bus.start;
  assign bad0 = (bus.s0 != exp);
  assign bad1 = (bus.s1 != exp);

  // Next value of the result registers for the current sample.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    cov_d  = cov_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    fev_d  = fev_q;
    fvec_d = fvec_q;
    fsrc_d = fsrc_q;
    if (bus.start) begin
      cov_d  = '0;
      err_d  = '0;
      cnt_d  = '0;
      fev_d  = 1'b0;
      fvec_d = '0;
      fsrc_d = '0;
    end else if (take) begin
      cov_d = cov_q | (NUM_VEC'(1) << idx);
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (bad0 || bad1) begin
        if (err_q != '1) err_d = err_q + 1'b1;
        // Only the first failure of a run is kept for diagnosis.
        if (!fev_q) begin
          fev_d  = 1'b1;
          fvec_d = idx;
          fsrc_d = {bad0, bad1};
        end
      end
    end
  end

  // Run sequencing: start always (re)enters RUN; completion of coverage or
  // exhaustion of the sample budget, counting this sample, ends the run.
  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (take && (cov_d == ALL_COVERED || cnt_d == MAX_CNT)) state_d = DONE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Pass is judged only on the final results; an exhausted budget with a
  // coverage hole leaves cov_d short of ALL_COVERED and so fails.
  assign pass_d = (state_d == DONE) && (cov_d == ALL_COVERED) && (err_d == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values, independent of statement order.
      state_q <= state_d;
    end
  end

  // Result and status registers; status flags are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these are a handful of flops rather than a memory array, so every one is reset and nothing is observable as X.
      cov_q  <= '0;
      err_q  <= '0;
      cnt_q  <= '0;
      fev_q  <= 1'b0;
      fvec_q <= '0;
      fsrc_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      cov_q  <= cov_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      fev_q  <= fev_d;
      fvec_q <= fvec_d;
      fsrc_q <= fsrc_d;
      busy_q <= (state_d == RUN);
      done_q <= (state_d == DONE);
      pass_q <= pass_d;
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.coverage        = cov_q;
  assign bus.err_cnt         = err_q;
  assign bus.sample_cnt      = cnt_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_vec   = fvec_q;
  assign bus.first_err_src   = fsrc_q;

endmodule

// File: tb/tb_distributive_checker.sv
// Self-checking bench for distributive_checker. Three instances with
// different budgets/widths see the same stimulus; a behavioural model built
// from the checker's rules tracks each one every cycle, and directed tables
// and sequences pin the documented corner cases with literal expectations.
module tb_distributive_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sample_en = 1'b0;
  logic x = 1'b0, y = 1'b0, z = 1'b0, s0 = 1'b0, s1 = 1'b0;

  always #5 clk = ~clk;

  distributive_checker_if #(.CNT_W(8)) bus_a ();
  distributive_checker_if #(.CNT_W(8)) bus_b ();
  distributive_checker_if #(.CNT_W(4)) bus_c ();

  assign bus_a.start = start;  assign bus_a.sample_en = sample_en;
  assign bus_a.x = x;  assign bus_a.y = y;  assign bus_a.z = z;
  assign bus_a.s0 = s0;  assign bus_a.s1 = s1;
  assign bus_b.start = start;  assign bus_b.sample_en = sample_en;
  assign bus_b.x = x;  assign bus_b.y = y;  assign bus_b.z = z;
  assign bus_b.s0 = s0;  assign bus_b.s1 = s1;
  assign bus_c.start = start;  assign bus_c.sample_en = sample_en;
  assign bus_c.x = x;  assign bus_c.y = y;  assign bus_c.z = z;
  assign bus_c.s0 = s0;  assign bus_c.s1 = s1;

  distributive_checker #(.CNT_W(8), .MAX_SAMPLES(64)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  distributive_checker #(.CNT_W(8), .MAX_SAMPLES(10)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  distributive_checker #(.CNT_W(4), .MAX_SAMPLES(15)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // st: 0 = not running, 1 = running, 2 = finished.
  typedef struct {
    int       st;
    bit [7:0] cov;
    int       errs;
    int       samples;
    bit       fev;
    bit [2:0] fvec;
    bit [1:0] fsrc;
    bit       pass;
  } model_t;

  model_t m[3];
  int max_s[3]   = '{64, 10, 15};
  int err_max[3] = '{255, 255, 15};

  function automatic bit golden(input bit [2:0] v);
    return v[2] || (v[1] && v[0]);
  endfunction

  function automatic void model_clear(input int k);
    m[k].st = 0;  m[k].cov = 8'h00;  m[k].errs = 0;  m[k].samples = 0;
    m[k].fev = 1'b0;  m[k].fvec = 3'b000;  m[k].fsrc = 2'b00;  m[k].pass = 1'b0;
  endfunction

  // One clock edge of the checker's rules applied to the current inputs.
  function automatic void model_step(input int k);
    int idx;
    bit e, b0, b1;
    if (!rst_n) begin
      model_clear(k);
    end else if (start) begin
      model_clear(k);
      m[k].st = 1;
    end else if (m[k].st == 1 && sample_en) begin
      idx = int'(x) * 4 + int'(y) * 2 + int'(z);
      e   = golden(3'(idx));
      b0  = (s0 != e);
      b1  = (s1 != e);
      m[k].cov[idx] = 1'b1;
      m[k].samples++;
      if (b0 || b1) begin
        if (m[k].errs < err_max[k]) m[k].errs++;
        if (!m[k].fev) begin
          m[k].fev = 1'b1;  m[k].fvec = 3'(idx);  m[k].fsrc = {b0, b1};
        end
      end
      if (m[k].cov == 8'hFF) begin
        m[k].st = 2;  m[k].pass = (m[k].errs == 0);
      end else if (m[k].samples == max_s[k]) begin
        m[k].st = 2;  m[k].pass = 1'b0;
      end
    end
  endfunction

  function automatic logic [63:0] model_pack(input int k);
    logic [32:0] p;
    p = {m[k].st == 1, m[k].st == 2, m[k].pass, m[k].cov, 8'(m[k].errs),
         8'(m[k].samples), m[k].fev, m[k].fvec, m[k].fsrc};
    return 64'(p);
  endfunction

  function automatic logic [63:0] dut_pack(input int k);
    logic [32:0] p;
    case (k)
      0: p = {bus_a.busy, bus_a.done, bus_a.pass, bus_a.coverage, bus_a.err_cnt,
              bus_a.sample_cnt, bus_a.first_err_valid, bus_a.first_err_vec, bus_a.first_err_src};
      1: p = {bus_b.busy, bus_b.done, bus_b.pass, bus_b.coverage, bus_b.err_cnt,
              bus_b.sample_cnt, bus_b.first_err_valid, bus_b.first_err_vec, bus_b.first_err_src};
      default: p = {bus_c.busy, bus_c.done, bus_c.pass, bus_c.coverage, 8'(bus_c.err_cnt),
              8'(bus_c.sample_cnt), bus_c.first_err_valid, bus_c.first_err_vec, bus_c.first_err_src};
    endcase
    return 64'(p);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input bit st, input bit se, input bit [2:0] v, input bit a, input bit b);
    start = st;  sample_en = se;  x = v[2];  y = v[1];  z = v[0];  s0 = a;  s1 = b;
  endtask

  // Advance one clock, step the model on the same inputs, compare all instances.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("model_dut%0d_cyc%0d", k, cyc), dut_pack(k), model_pack(k));
    cyc++;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit       st;
    bit       se;
    bit [2:0] v;
    bit       s0;
    bit       s1;
    bit       busy;
    bit       done;
    bit       pass;
    bit [7:0] cov;
    bit [7:0] err;
    bit [7:0] cnt;
  } vec_t;

  function automatic vec_t mk(input bit st, input bit se, input bit [2:0] v, input bit a, input bit b,
                              input bit busy, input bit done, input bit pass,
                              input bit [7:0] cov, input bit [7:0] err, input bit [7:0] cnt);
    vec_t r;
    r.st = st;  r.se = se;  r.v = v;  r.s0 = a;  r.s1 = b;
    r.busy = busy;  r.done = done;  r.pass = pass;  r.cov = cov;  r.err = err;  r.cnt = cnt;
    return r;
  endfunction

  vec_t tbl[18];

  initial begin
    bit e;
    bit [7:0] cov_acc;
    bit [7:0] err_acc;

    // Clean sweep: vectors 0..2 have exp 0, 3..7 have exp 1.
    tbl[0] = mk(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 8'd0);
    cov_acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      e = (i >= 3);
      cov_acc[i] = 1'b1;
      tbl[1 + i] = mk(1'b0, 1'b1, 3'(i), e, e, i != 7, i == 7, i == 7, cov_acc, 8'd0, 8'(i + 1));
    end
    // Restart out of DONE, then sweep with s1 stuck at 0: errors on 3..7.
    tbl[9] = mk(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 8'd0);
    cov_acc = 8'h00;
    err_acc = 8'd0;
    for (int i = 0; i < 8; i++) begin
      e = (i >= 3);
      cov_acc[i] = 1'b1;
      if (e) err_acc++;
      tbl[10 + i] = mk(1'b0, 1'b1, 3'(i), e, 1'b0, i != 7, i == 7, 1'b0, cov_acc, err_acc, 8'(i + 1));
    end

    for (int k = 0; k < 3; k++) model_clear(k);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("reset_dut%0d", k), dut_pack(k), 64'd0);
    rst_n = 1'b1;

    // Sample strobes in IDLE are ignored.
    set_in(1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
    tick();
    check("idle_ignore_cnt", 64'(bus_a.sample_cnt), 64'd0);

    // Table: clean sweep then stuck-at fault sweep on dut_a.
    for (int i = 0; i < 18; i++) begin
      set_in(tbl[i].st, tbl[i].se, tbl[i].v, tbl[i].s0, tbl[i].s1);
      tick();
      check($sformatf("tbl%0d", i),
            64'({bus_a.busy, bus_a.done, bus_a.pass, bus_a.coverage, bus_a.err_cnt, bus_a.sample_cnt}),
            64'({tbl[i].busy, tbl[i].done, tbl[i].pass, tbl[i].cov, tbl[i].err, tbl[i].cnt}));
    end
    check("fault_first_valid", 64'(bus_a.first_err_valid), 64'd1);
    check("fault_first_vec", 64'(bus_a.first_err_vec), 64'(3'b011));
    check("fault_first_src", 64'(bus_a.first_err_src), 64'(2'b01));

    // Incomplete coverage on dut_b (budget 10): 0..6 then 0,1,2.
    set_in(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      bit [2:0] v;
      v = (i < 7) ? 3'(i) : 3'(i - 7);
      set_in(1'b0, 1'b1, v, golden(v), golden(v));
      tick();
      if (i == 8) check("incomp_busy_at_9", 64'({bus_b.busy, bus_b.done}), 64'(2'b10));
    end
    check("incomp_done", 64'({bus_b.busy, bus_b.done, bus_b.pass}), 64'(3'b010));
    check("incomp_cov", 64'(bus_b.coverage), 64'h7F);
    check("incomp_err", 64'(bus_b.err_cnt), 64'd0);
    check("incomp_cnt", 64'(bus_b.sample_cnt), 64'd10);

    // Saturation on dut_c (4-bit, budget 15): s0 inverted, vectors 0..6 cycling.
    set_in(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 15; i++) begin
      bit [2:0] v;
      v = 3'(i % 7);
      set_in(1'b0, 1'b1, v, !golden(v), golden(v));
      tick();
      if (i == 13) check("sat_busy_at_14", 64'({bus_c.busy, bus_c.done}), 64'(2'b10));
    end
    check("sat_done", 64'({bus_c.busy, bus_c.done, bus_c.pass}), 64'(3'b010));
    check("sat_err", 64'(bus_c.err_cnt), 64'hF);
    check("sat_cnt", 64'(bus_c.sample_cnt), 64'hF);
    check("sat_src", 64'(bus_c.first_err_src), 64'(2'b10));
    // Strobes in DONE leave results untouched.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
      tick();
    end
    check("done_hold", 64'({bus_c.done, bus_c.coverage, bus_c.err_cnt, bus_c.sample_cnt}),
          64'({1'b1, 8'h7F, 4'hF, 4'hF}));

    // Restart with a simultaneous strobe: that sample is discarded.
    set_in(1'b1, 1'b1, 3'd7, 1'b1, 1'b1);
    tick();
    check("restart_a", 64'({bus_a.busy, bus_a.done, bus_a.coverage, bus_a.sample_cnt}),
          64'({1'b1, 1'b0, 8'h00, 8'd0}));
    check("restart_c", 64'({bus_c.busy, bus_c.done, bus_c.err_cnt, bus_c.first_err_valid}),
          64'({1'b1, 1'b0, 4'h0, 1'b0}));

    // Reset mid-run after 4 samples.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b1, 3'(i), 1'b0, 1'b1);
      tick();
    end
    check("midrun_cnt", 64'(bus_a.sample_cnt), 64'd4);
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      model_clear(k);
      check($sformatf("midrun_rst_dut%0d", k), dut_pack(k), 64'd0);
    end
    set_in(1'b0, 1'b1, 3'd6, 1'b1, 1'b1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("post_rst_ignore", 64'({bus_a.busy, bus_a.sample_cnt}), 64'd0);

    // Randomised traffic checked against the model.
    for (int i = 0; i < 600; i++) begin
      bit [2:0] v;
      bit st, se, a, b;
      v  = 3'($urandom_range(0, 7));
      st = ($urandom_range(0, 99) < 3);
      se = ($urandom_range(0, 99) < 60);
      a  = golden(v) ^ ($urandom_range(0, 9) == 0);
      b  = golden(v) ^ ($urandom_range(0, 9) == 0);
      set_in(st, se, v, a, b);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
